// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-word bit positions and register constants.
package id_ex_stage_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside the packed control word {regwrite,memread,...,aluop[1:0],valid}
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_VALID    = 0;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection; a flush overrides the stall so the PC can redirect.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_memread,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       id_valid,
  input  logic       flush,
  output logic       hazard,
  output logic       pc_write,
  output logic       if_id_write
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = (ex_rd == id_rs1);
  assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);

  // x0 is never a real producer, so a load targeting it cannot create a dependency
  assign hazard = ex_memread && ex_valid && (ex_rd != REG_X0) &&
                  (rs1_match || rs2_match) && id_valid;

  assign pc_write    = !hazard || flush;
  assign if_id_write = !hazard || flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register; inserts a bubble on flush or load-use hazard and counts both.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [4:0]           id_rd,
  input  logic                 id_uses_rs2,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 flush,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic hazard;
  logic bubble;

  hazard_detect u_hazard_detect (
    .ex_memread  (ex_ctrl[CTRL_MEMREAD]),
    .ex_valid    (ex_ctrl[CTRL_VALID]),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .id_valid    (id_ctrl[CTRL_VALID]),
    .flush       (flush),
    .hazard      (hazard),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  assign bubble = flush || hazard;

  // Data registers always load; only control and indices are squashed on a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
    end else begin
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
    end
  end

  // Zeroed indices keep the forwarding unit from matching on a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl <= '0;
      ex_rs1  <= REG_X0;
      ex_rs2  <= REG_X0;
      ex_rd   <= REG_X0;
    end else if (bubble) begin
      ex_ctrl <= '0;
      ex_rs1  <= REG_X0;
      ex_rs2  <= REG_X0;
      ex_rd   <= REG_X0;
    end else begin
      ex_ctrl <= id_ctrl;
      ex_rs1  <= id_rs1;
      ex_rs2  <= id_rs2;
      ex_rd   <= id_rd;
    end
  end

  // A simultaneous flush and hazard is accounted as a flush only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end else if (hazard) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
